// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Two-entry pipeline register with a skid entry. The main entry drives the
//   outputs; the skid entry catches one extra entry when downstream stalls.
//   in_ready depends only on registered state, so no combinational path runs
//   from out_ready back to in_ready.
//
// Handshake: an entry moves across a port on a rising edge where valid and
//   ready are both 1. Once raised, out_valid stays high with stable
//   out_data/out_ctrl until taken, flushed or reset.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset (beats flush/in_valid/out_ready)
//   in_valid   upstream entry valid
//   in_ready   stage can accept (state EMPTY or ONE)
//   in_data    upstream datapath payload [DATA_W]
//   in_ctrl    upstream control payload  [CTRL_W]
//   flush      drop all held entries at the next edge
//   out_valid  downstream entry valid (state ONE or FULL)
//   out_ready  downstream takes the entry this cycle
//   out_data   main entry payload; holds its last value while empty
//   out_ctrl   main entry control; zero whenever out_valid = 0
//   occupancy  held entries 0..2 (this is the registered state, for debug)
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;

  state_t              w_state_nxt;
  logic [DATA_W-1:0]   w_main_data_nxt;
  logic [CTRL_W-1:0]   w_main_ctrl_nxt;
  logic [DATA_W-1:0]   w_skid_data_nxt;
  logic [CTRL_W-1:0]   w_skid_ctrl_nxt;
  logic                w_accept;
  logic                w_take;

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main_data;
  // Main ctrl is cleared on every move into EMPTY, so it is already a bubble.
  assign out_ctrl  = r_main_ctrl;
  assign occupancy = r_state;

  assign w_accept = in_valid & in_ready;
  assign w_take   = out_valid & out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;

    unique case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt     = ONE;
          w_main_data_nxt = in_data;
          w_main_ctrl_nxt = in_ctrl;
        end
      end
      ONE: begin
        if (w_accept && w_take) begin
          w_main_data_nxt = in_data;
          w_main_ctrl_nxt = in_ctrl;
        end else if (w_accept) begin
          w_state_nxt     = FULL;
          w_skid_data_nxt = in_data;
          w_skid_ctrl_nxt = in_ctrl;
        end else if (w_take) begin
          w_state_nxt     = EMPTY;
          w_main_ctrl_nxt = '0;
        end
      end
      FULL: begin
        if (w_take) begin
          w_state_nxt     = ONE;
          w_main_data_nxt = r_skid_data;
          w_main_ctrl_nxt = r_skid_ctrl;
          w_skid_ctrl_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = EMPTY;
        w_main_ctrl_nxt = '0;
        w_skid_ctrl_nxt = '0;
      end
    endcase

    // Flush overrides everything above: a same-cycle input is dropped and
    // out_data keeps showing the last main value. A take in this cycle has
    // already happened on the downstream side, so nothing extra is needed.
    if (flush) begin
      w_state_nxt     = EMPTY;
      w_main_data_nxt = r_main_data;
      w_main_ctrl_nxt = '0;
      w_skid_data_nxt = r_skid_data;
      w_skid_ctrl_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  localparam int DW = 32;
  localparam int CW = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  // scoreboard: FIFO of held entries, oldest first
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] exp_c[$];
  logic [DW-1:0] last_data = '0;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic fl, input logic ordy, input logic r);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    flush     = fl;
    out_ready = ordy;
    rst       = r;
  endtask

  // One clock edge: the model decides accept/take from the entry count before
  // the edge, updates the queue, then all outputs are compared 1 ns after.
  task automatic step(input string tag);
    bit acc, tk;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    int n;
    n   = exp_q.size();
    acc = in_valid && (n < 2);
    tk  = (n > 0) && out_ready;
    d   = in_data;
    c   = in_ctrl;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_c.delete();
      last_data = '0;
    end else begin
      if (tk) begin
        void'(exp_q.pop_front());
        void'(exp_c.pop_front());
      end
      if (flush) begin
        exp_q.delete();
        exp_c.delete();
      end else if (acc) begin
        exp_q.push_back(d);
        exp_c.push_back(c);
      end
      if (exp_q.size() > 0) last_data = exp_q[0];
    end
    check({tag, "_occ"},   64'(occupancy), 64'(exp_q.size()));
    check({tag, "_ovld"},  64'(out_valid), 64'(exp_q.size() > 0));
    check({tag, "_irdy"},  64'(in_ready),  64'(exp_q.size() < 2));
    check({tag, "_odata"}, 64'(out_data),  64'((exp_q.size() > 0) ? exp_q[0] : last_data));
    check({tag, "_octrl"}, 64'(out_ctrl),  64'((exp_c.size() > 0) ? exp_c[0] : '0));
  endtask

  initial begin
    // reset
    drive(0, '0, '0, 0, 0, 1); step("rst");
    check("rst_occ0", 64'(occupancy), 64'd0);
    check("rst_irdy", 64'(in_ready), 64'd1);
    check("rst_data", 64'(out_data), 64'd0);

    // streaming
    drive(1, 32'h12345678, 16'h00A1, 0, 1, 0); step("str1");
    check("str1_val", 64'(out_data), 64'h12345678);
    drive(1, 32'h87654321, 16'h00A2, 0, 1, 0); step("str2");
    check("str2_val", 64'(out_data), 64'h87654321);
    check("str2_occ", 64'(occupancy), 64'd1);
    drive(0, '0, '0, 0, 1, 0); step("str_drain");
    check("bubble_hold", 64'(out_data), 64'h87654321);

    // backpressure
    drive(1, 32'hABCDEFFF, 16'h0B01, 0, 0, 0); step("bp1");
    drive(1, 32'h00000005, 16'h0B02, 0, 0, 0); step("bp2");
    check("bp2_occ", 64'(occupancy), 64'd2);
    check("bp2_irdy", 64'(in_ready), 64'd0);
    drive(1, 32'h0000000A, 16'h0B03, 0, 0, 0); step("bp3");
    check("bp3_head", 64'(out_data), 64'hABCDEFFF);
    drive(0, '0, '0, 0, 1, 0); step("bp_d1");
    check("bp_d1_val", 64'(out_data), 64'h00000005);
    step("bp_d2");
    check("bp_d2_occ", 64'(occupancy), 64'd0);

    // flush while full, with a valid input
    drive(1, 32'h00000101, 16'h0C01, 0, 0, 0); step("fl_f1");
    drive(1, 32'h00000202, 16'h0C02, 0, 0, 0); step("fl_f2");
    drive(1, 32'h00000303, 16'h0C03, 1, 0, 0); step("flush");
    check("flush_ctrl", 64'(out_ctrl), 64'd0);
    drive(0, '0, '0, 0, 1, 0); step("flush_idle");

    // simultaneous accept and take in ONE
    drive(1, 32'h00000011, 16'h0D01, 0, 0, 0); step("sim1");
    drive(1, 32'h00000022, 16'h0D02, 0, 1, 0); step("sim2");
    check("sim2_occ", 64'(occupancy), 64'd1);
    drive(0, '0, '0, 0, 0, 0); step("sim_hold");
    drive(0, '0, '0, 0, 1, 0); step("sim_drain");
    check("sim_drain_occ", 64'(occupancy), 64'd0);

    // mid-operation reset
    drive(1, 32'h00000044, 16'h0E01, 0, 0, 0); step("mr1");
    drive(1, 32'h00000055, 16'h0E02, 0, 0, 0); step("mr2");
    drive(1, 32'h00000099, 16'h0E03, 0, 1, 1); step("mrst");
    check("mrst_data", 64'(out_data), 64'd0);
    check("mrst_irdy", 64'(in_ready), 64'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, DW'($urandom), CW'($urandom),
            $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 99) == 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of the datapath payload (operands, immediates, register numbers packed by the user).
REQ-002 Parameter CTRL_W, default 16, width of the control payload (RegWrite, MemRead, MemWrite, ALUOp, etc.); it is zeroed on bubble/flush.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream stage presents a valid entry.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_data  input  DATA_W  upstream datapath payload.
REQ-008 in_ctrl  input  CTRL_W  upstream control payload.
REQ-009 flush  input  1  discard all held entries (branch/jump redirect).
REQ-010 out_valid  output  1  downstream entry valid.
REQ-011 out_ready  input  1  downstream accepts the entry this cycle.
REQ-012 out_data  output  DATA_W  downstream datapath payload.
REQ-013 out_ctrl  output  CTRL_W  downstream control payload; all-zero whenever out_valid=0.
REQ-014 occupancy  output  2  number of held entries, 0..2.

Function
REQ-015 Storage SHALL be two entries: main (drives outputs) and skid (overflow); each entry holds data and ctrl.
REQ-016 States SHALL be EMPTY (occupancy 0), ONE (1), FULL (2); occupancy is the registered state encoding.
REQ-017 Accept = in_valid & in_ready; take = out_valid & out_ready.
REQ-018 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL; it is a function of registered state only (no combinational path from out_ready).
REQ-019 out_valid SHALL be 1 in ONE and FULL; out_data/out_ctrl SHALL come from main.
REQ-020 EMPTY: accept -> ONE, main <= input; else stay.
REQ-021 ONE: accept & take -> ONE, main <= input; accept & !take -> FULL, skid <= input; !accept & take -> EMPTY; else hold.
REQ-022 FULL: take -> ONE, main <= skid; else hold all.
REQ-023 Latency SHALL be one cycle: an entry accepted at edge N is on the outputs after edge N.
REQ-024 No entry SHALL be dropped, duplicated or reordered while flush=0 and rst=0.
REQ-025 When out_valid=0, out_ctrl SHALL be zero (bubble); out_data holds its last main value.
REQ-026 flush=1 SHALL move to EMPTY at the next edge, zeroing main/skid ctrl; an input accepted in the same cycle is discarded.
REQ-027 flush=1 together with out_ready=1 SHALL still count the current main entry as taken by downstream (flush acts after that edge).
REQ-028 Throughput SHALL be one entry per cycle with out_ready held 1.

Reset
REQ-029 rst=1 at an edge SHALL force EMPTY, occupancy=0, out_valid=0, in_ready=1, out_data=0, out_ctrl=0, skid contents=0.
REQ-030 rst SHALL take priority over flush, in_valid and out_ready; mid-operation reset discards both entries.

Verification
REQ-031 Reset: rst=1 one edge -> occupancy=0, out_valid=0, in_ready=1, out_data=0, out_ctrl=0.
REQ-032 Streaming: out_ready=1, in_data=32'h12345678 then 32'h87654321 on consecutive cycles -> each appears one cycle later, occupancy stays 1, in_ready stays 1.
REQ-033 Backpressure: out_ready=0, push 32'hABCDEFFF, 32'h00000005, 32'h0000000A -> occupancy 1,2,2; in_ready=0 after second; third not accepted; raising out_ready drains ABCDEFFF then 00000005 in order.
REQ-034 Flush: FULL, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=16'h0000, input discarded.
REQ-035 Simultaneous: ONE with in_valid=1, out_ready=1 -> main replaced, occupancy stays 1, no skid write.
REQ-036 Mid-operation reset: FULL, rst=1 with in_valid=1, flush=0 -> EMPTY, all outputs at reset values.
